// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FP adder arbiter slice.
package fpu_arb_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic error;
    logic overflow;
    logic underflow;
  } fpu_flags_t;
endpackage

// File: rtl/fpu_adder_top.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
module fpu_adder_top
  import fpu_arb_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] result,
  output fpu_flags_t      flags
);
  logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, inc, inexact, lz_done;
  logic [31:0] x, y;
  logic [9:0]  ex, ey, d, lz, sh, e;
  logic [23:0] mx, my;
  logic [26:0] yext, al, lost, n;
  logic [27:0] s;
  logic [24:0] mr;

  // Align, add/subtract, normalise, round, then override with special cases.
  always_comb begin
    result  = '0;
    flags   = '0;
    al      = '0;
    lost    = '0;
    sh      = '0;
    lz      = '0;
    lz_done = 1'b0;
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);
    // x is the larger magnitude so the aligned difference is never negative
    swap = b[30:0] > a[30:0];
    x    = swap ? b : a;
    y    = swap ? a : b;
    // subnormals behave as exponent 1 with no hidden bit
    ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
    mx = {|x[30:23], x[22:0]};
    my = {|y[30:23], y[22:0]};
    d  = ex - ey;
    yext = {my, 3'b000};
    if (d >= 10'd27) begin
      al[0] = |my;
    end else begin
      al    = yext >> d;
      lost  = yext << (10'd27 - d);
      al[0] = al[0] | (|lost);
    end
    eff_sub = x[31] ^ y[31];
    s = eff_sub ? ({1'b0, mx, 3'b000} - {1'b0, al}) : ({1'b0, mx, 3'b000} + {1'b0, al});
    for (int i = 26; i >= 0; i--) begin
      if (!lz_done) begin
        if (s[i]) lz_done = 1'b1;
        else      lz = lz + 10'd1;
      end
    end
    if (s[27]) begin
      n    = s[27:1];
      n[0] = s[1] | s[0];
      e    = ex + 10'd1;
    end else begin
      // never shift below exponent 1; what remains is a subnormal
      sh = (lz > ex - 10'd1) ? ex - 10'd1 : lz;
      n  = s[26:0] << sh;
      e  = ex - sh;
    end
    inc     = n[2] & (n[1] | n[0] | n[3]);
    inexact = |n[2:0];
    mr      = {1'b0, n[26:3]} + {24'b0, inc};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'd1;
    end
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      result      = QNAN;
      flags.error = 1'b1;
    end else if (a_inf) begin
      result = a;
    end else if (b_inf) begin
      result = b;
    end else if (s == '0) begin
      result = {x[31] & y[31], 31'b0};
    end else if (e >= 10'd255) begin
      result         = {x[31], 8'hFF, 23'b0};
      flags.overflow = 1'b1;
    end else begin
      result          = {x[31], (mr[23] ? e[7:0] : 8'h00), mr[22:0]};
      flags.underflow = ~mr[23] & inexact;
    end
  end
endmodule

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr, wrapping.
module fpu_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);
  int p;

  // Scan N_REQ slots starting at rr_ptr; the wrap is an explicit subtract.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    p         = 0;
    for (int off = 0; off < N_REQ; off++) begin
      p = int'(rr_ptr) + off;
      if (p >= N_REQ) p = p - N_REQ;
      if (!grant_any && req_valid[p]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(p);
      end
    end
  end
endmodule

// File: rtl/fpu_adder_arbiter.sv
// Round-robin front end sharing one combinational FP adder among N_REQ requesters.
module fpu_adder_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [31:0]        rsp_result,
  output logic [2:0]         rsp_flags,
  output logic               busy
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr, grant, pick_idx;
  logic              pick_any;
  logic [CNT_W-1:0]  cnt;
  logic [FP_W-1:0]   op_a, op_b, sum;
  fpu_flags_t        add_flags;

  fpu_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  // Operands come only from the captured registers, so the adder sees stable inputs.
  fpu_adder_top u_add (
    .a      (op_a),
    .b      (op_b),
    .result (sum),
    .flags  (add_flags)
  );

  assign busy = (state != IDLE);

  // Next state and one-hot handshakes; requests are only accepted from IDLE.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE: if (pick_any) begin
        req_ready[pick_idx] = 1'b1;
        state_nxt           = EXEC;
      end
      EXEC: if (cnt == '0) state_nxt = RESP;
      RESP: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_ready[grant]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, operand capture, settle counter, result registers and rr pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pick_any) begin
          op_a  <= req_a[pick_idx*FP_W +: FP_W];
          op_b  <= req_b[pick_idx*FP_W +: FP_W];
          grant <= pick_idx;
          cnt   <= CNT_W'(WAIT_CYCLES - 1);
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_result <= sum;
            rsp_flags  <= add_flags;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: if (rsp_ready[grant]) begin
          rr_ptr <= (grant == PTR_W'(N_REQ - 1)) ? '0 : grant + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_adder_arbiter.sv
// Self-checking bench for fpu_adder_arbiter (N_REQ=2, WAIT_CYCLES=1).
module tb_fpu_adder_arbiter;
  localparam int N = 2;
  localparam int W = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     rsp_result;
  logic [2:0]      rsp_flags;
  logic            busy;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_adder_arbiter #(.N_REQ(N), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Exact single-precision encoding of a small integer (|v| < 2^24).
  function automatic logic [31:0] i2f(input int v);
    int m, p;
    logic [31:0] r, t;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    t = 32'(m) << (23 - p);
    r = {(v < 0), 8'(127 + p), t[22:0]};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (rsp_result !== 32'h0 || rsp_flags !== 3'b000) begin n_fail++; $display("FAIL reset_result got %h/%b exp 0/000", rsp_result, rsp_flags); end
  endtask

  task automatic test_single();
    do_reset();
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h3F800000; req_valid = 2'b01; #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b exp 01", req_ready); end
    step(); req_valid = '0; #1;
    n_tests++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL single_exec got %b/%b exp 00/1", rsp_valid, busy); end
    step();
    n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid got %b exp 01", rsp_valid); end
    n_tests++; if (rsp_result !== 32'h40000000 || rsp_flags !== 3'b000) begin n_fail++; $display("FAIL single_result got %h/%b exp 40000000/000", rsp_result, rsp_flags); end
    rsp_ready = 2'b01; step(); rsp_ready = '0; #1;
    n_tests++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_done got busy %b rsp %b exp 0/00", busy, rsp_valid); end
  endtask

  task automatic test_rr();
    rst = 1'b1; rsp_ready = '0;
    req_a = {32'h40600000, 32'h3F000000}; req_b = {32'hC0200000, 32'h3E800000};
    req_valid = 2'b11;
    step(); step(); rst = 1'b0; #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rr_first got %b exp 01", req_ready); end
    step(); req_valid = 2'b10; #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_exec_block got %b exp 00", req_ready); end
    step();
    n_tests++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h3F400000) begin n_fail++; $display("FAIL rr_rsp0 got %b/%h exp 01/3f400000", rsp_valid, rsp_result); end
    rsp_ready = 2'b01; step(); rsp_ready = '0; #1;
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rr_second got %b exp 10", req_ready); end
    step(); req_valid = '0; step();
    n_tests++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h3F800000) begin n_fail++; $display("FAIL rr_rsp1 got %b/%h exp 10/3f800000", rsp_valid, rsp_result); end
    rsp_ready = 2'b10; step(); rsp_ready = '0;
    req_valid = 2'b11; #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rr_ptr_wrap got %b exp 01", req_ready); end
  endtask

  task automatic test_special();
    logic [31:0] ta [2], tb_ [2], tr [2];
    logic [2:0]  tf [2];
    ta[0] = 32'h7F800000; tb_[0] = 32'hFF800000; tr[0] = 32'h7FC00000; tf[0] = 3'b100;
    ta[1] = 32'h7F7FFFFF; tb_[1] = 32'h7F7FFFFF; tr[1] = 32'h7F800000; tf[1] = 3'b010;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req_a[63:32] = ta[k]; req_b[63:32] = tb_[k]; req_valid = 2'b10; #1;
      n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL special%0d_ready got %b exp 10", k, req_ready); end
      step(); req_valid = '0; step();
      n_tests++; if (rsp_valid !== 2'b10 || rsp_result !== tr[k] || rsp_flags !== tf[k]) begin
        n_fail++; $display("FAIL special%0d got %b/%h/%b exp 10/%h/%b", k, rsp_valid, rsp_result, rsp_flags, tr[k], tf[k]);
      end
      rsp_ready = 2'b10; step(); rsp_ready = '0;
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    req_a[31:0] = i2f(7); req_b[31:0] = i2f(-3); req_valid = 2'b01;
    step(); req_valid = 2'b10; step();
    rsp_ready = 2'b10;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid !== 2'b01 || rsp_result !== 32'h40800000 || req_ready !== 2'b00 || busy !== 1'b1) bad++;
      step();
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL backpressure_hold got %0d bad cycles exp 0 (last %b/%h/%b)", bad, rsp_valid, rsp_result, req_ready); end
    rsp_ready = 2'b01; step(); rsp_ready = '0; #1;
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL backpressure_release got %b exp 10", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h3F800000; req_valid = 2'b01;
    step(); req_valid = '0; rst = 1'b1;
    step(); rst = 1'b0; #1;
    n_tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_mid got %b/%b/%h exp 00/0/0", rsp_valid, busy, rsp_result); end
    for (int c = 0; c < 6; c++) begin step(); if (rsp_valid !== 2'b00) seen++; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_ghost got %0d rsp cycles exp 0", seen); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_a = {i2f(2), i2f(5)}; req_b = {i2f(2), i2f(5)}; req_valid = 2'b01;
    step(); req_valid = '0; step();
    rsp_ready = 2'b01; req_valid = 2'b10; #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL b2b_same_cycle got %b exp 00", req_ready); end
    step(); rsp_ready = '0; #1;
    n_tests++; if (req_ready !== 2'b10 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_next_cycle got %b/%b exp 10/0", req_ready, busy); end
    step(); req_valid = '0; step();
    n_tests++; if (rsp_result !== i2f(4)) begin n_fail++; $display("FAIL b2b_result got %h exp %h", rsp_result, i2f(4)); end
    rsp_ready = 2'b10; step(); rsp_ready = '0;
  endtask

  // Transaction-level model: grant = first pending index at/after the one after the last served.
  task automatic test_random();
    int ptr, g, lat, hold;
    int va [N], vb [N];
    logic [N-1:0] mask, expv;
    do_reset();
    ptr = 0;
    for (int r = 0; r < 40; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        va[i] = int'($urandom_range(0, 200000)) - 100000;
        vb[i] = int'($urandom_range(0, 200000)) - 100000;
        req_a[i*32 +: 32] = i2f(va[i]);
        req_b[i*32 +: 32] = i2f(vb[i]);
      end
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && mask[(ptr + k) % N]) g = (ptr + k) % N;
      expv = N'(1) << g;
      req_valid = mask; #1;
      n_tests++; if (req_ready !== expv) begin n_fail++; $display("FAIL rand%0d_grant got %b exp %b", r, req_ready, expv); end
      step(); req_valid = '0; lat = 0;
      while (rsp_valid === '0 && lat < 10) begin step(); lat++; end
      n_tests++; if (lat !== W || rsp_valid !== expv) begin n_fail++; $display("FAIL rand%0d_latency got %0d/%b exp %0d/%b", r, lat, rsp_valid, W, expv); end
      n_tests++; if (rsp_result !== i2f(va[g] + vb[g]) || rsp_flags !== 3'b000) begin
        n_fail++; $display("FAIL rand%0d_result got %h/%b exp %h/000 (%0d+%0d)", r, rsp_result, rsp_flags, i2f(va[g] + vb[g]), va[g], vb[g]);
      end
      hold = int'($urandom_range(0, 3));
      rsp_ready = ~expv;
      repeat (hold) step();
      n_tests++; if (rsp_valid !== expv) begin n_fail++; $display("FAIL rand%0d_hold got %b exp %b", r, rsp_valid, expv); end
      rsp_ready = expv; step(); rsp_ready = '0;
      ptr = (g + 1) % N;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_special();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
